sbox_share_arbiter: RTL and testbench

Time-shares one 32-bit S-box substitution unit (four byte S-boxes, registered, fixed LAT-cycle latency, no stall, no reset) between two requesters: requester 0 is the round datapath (SubBytes of a column) and requester 1 is key expansion (SubWord). Requests are arbitrated round-robin with a valid/ready handshake. Each request's requester ID is tracked through a tag pipeline matching the S-box latency, so every result returns to its originator as a one-cycle pulse. The block sits between the cipher round controller, the key schedule and the shared S4 instance.

---
 rtl/aes_pkg.sv | 16 +
 rtl/sbox_tag_pipe.sv | 44 ++++
 rtl/sbox_share_arbiter.sv | 102 ++++++++++
 tb/tb_sbox_share_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and types used by the S-box sharing logic and the S4 wrapper.
package aes_pkg;

    localparam logic REQ_ROUND = 1'b0;
    localparam logic REQ_KEY   = 1'b1;

    // Default S-box latency; the S4 wrapper must be built with the same value.
    localparam int unsigned SBOX_LAT = 2;
    localparam int unsigned SBOX_W   = 32;

    typedef struct packed {
        logic v;
        logic id;
    } sbox_tag_t;

endpackage

// File: rtl/sbox_tag_pipe.sv
// Tag shift register that follows each word through the shared S-box and
// keeps a running count of valid stages.
module sbox_tag_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LAT = SBOX_LAT,
    parameter int unsigned CW  = $clog2(LAT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  sbox_tag_t     tag_i,
    output sbox_tag_t     tag_o,
    output logic [CW-1:0] inflight_o
);

    sbox_tag_t [LAT-1:0] stage_q;
    sbox_tag_t [LAT-1:0] stage_d;
    logic [CW-1:0]       inflight_q;
    logic [CW-1:0]       inflight_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_i;
        for (int k = 1; k < int'(LAT); k++) begin
            stage_d[k] = stage_q[k-1];
        end
        // One tag enters and one leaves per cycle, so the count moves by at most one.
        inflight_d = inflight_q + CW'(tag_i.v) - CW'(stage_q[LAT-1].v);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q    <= '0;
            inflight_q <= '0;
        end else begin
            stage_q    <= stage_d;
            inflight_q <= inflight_d;
        end
    end

    assign tag_o      = stage_q[LAT-1];
    assign inflight_o = inflight_q;

endmodule

// File: rtl/sbox_share_arbiter.sv
// Round-robin sharing of one S4 substitution unit between the round datapath
// and key expansion; results are routed back by a latency-matched tag pipe.
module sbox_share_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned LAT = SBOX_LAT,
    parameter int unsigned W   = SBOX_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [W-1:0]               req0_word,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [W-1:0]               req1_word,
    output logic [W-1:0]               sbox_in,
    input  logic [W-1:0]               sbox_out,
    output logic                       rsp0_valid,
    output logic                       rsp1_valid,
    output logic [W-1:0]               rsp_data,
    output logic                       idle,
    output logic [$clog2(LAT+1)-1:0]   inflight
);

    localparam int unsigned CW = $clog2(LAT + 1);

    logic      prio_q;
    logic      prio_d;
    logic      hs0;
    logic      hs1;
    sbox_tag_t tag_in;
    sbox_tag_t tag_out;

    // Readies are a function of valids and prio only; rst_n gating keeps them low during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (en && rst_n) begin
            if (req0_valid && req1_valid) begin
                req0_ready = (prio_q == REQ_ROUND);
                req1_ready = (prio_q == REQ_KEY);
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign hs0 = req0_valid & req0_ready;
    assign hs1 = req1_valid & req1_ready;

    always_comb begin
        sbox_in = '0;
        if (hs0) begin
            sbox_in = req0_word;
        end else if (hs1) begin
            sbox_in = req1_word;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (hs0) begin
            prio_d = REQ_KEY;
        end else if (hs1) begin
            prio_d = REQ_ROUND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= REQ_ROUND;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        tag_in    = '0;
        tag_in.v  = hs0 | hs1;
        tag_in.id = hs1 ? REQ_KEY : REQ_ROUND;
    end

    sbox_tag_pipe #(
        .LAT (LAT),
        .CW  (CW)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_i      (tag_in),
        .tag_o      (tag_out),
        .inflight_o (inflight)
    );

    assign rsp0_valid = tag_out.v & (tag_out.id == REQ_ROUND);
    assign rsp1_valid = tag_out.v & (tag_out.id == REQ_KEY);
    assign rsp_data   = sbox_out;
    assign idle       = (inflight == '0);

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Directed bench for sbox_share_arbiter with an attached two-stage AES S-box model
// and a scoreboard queue checked by an independent response monitor.
module tb_sbox_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_word;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_word;
    logic [31:0] sbox_in;
    logic [31:0] sbox_out;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic        idle;
    logic [1:0]  inflight;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic [31:0] x0;
    logic [31:0] x1;

    sbox_share_arbiter #(.LAT(2), .W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_word  (req0_word),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_word  (req1_word),
        .sbox_in    (sbox_in),
        .sbox_out   (sbox_out),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .idle       (idle),
        .inflight   (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sbox_tab [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [31:0] sub32(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Shared S4 model: registered, two cycles, no reset.
    logic [31:0] s1;
    logic [31:0] s2;
    always @(posedge clk) begin
        s1 <= sub32(sbox_in);
        s2 <= s1;
    end
    assign sbox_out = s2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (rsp0_valid || rsp1_valid)) begin
            if (rsp0_valid && rsp1_valid) begin
                n_checks++;
                n_err++;
                $display("FAIL rsp_both: got rsp0=1 rsp1=1 expected one-hot at %0t", $time);
            end else if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL rsp_unexpected: got rsp0=%b rsp1=%b expected none at %0t",
                         rsp0_valid, rsp1_valid, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", {31'b0, rsp1_valid}, {31'b0, e.id});
                chk("rsp_data", rsp_data, e.d);
            end
        end
    end

    task automatic drive(input logic v0, input logic [31:0] w0, input logic [31:0] e0,
                         input logic v1, input logic [31:0] w1, input logic [31:0] e1);
        req0_valid = v0;
        req0_word  = w0;
        x0         = e0;
        req1_valid = v1;
        req1_word  = w1;
        x1         = e1;
    endtask

    // One clock cycle: check grants, S-box input and occupancy, then log expected results.
    task automatic cyc(input logic er0, input logic er1, input int exp_if);
        logic [31:0] exp_sb;
        #2;
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, er0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, er1});
        exp_sb = er0 ? req0_word : (er1 ? req1_word : 32'h0);
        chk("sbox_in", sbox_in, exp_sb);
        chk("inflight", {30'b0, inflight}, exp_if);
        if (er0 && req0_valid) q.push_back('{id: 1'b0, d: x0});
        if (er1 && req1_valid) q.push_back('{id: 1'b1, d: x1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        drive(1'b1, 32'h00010203, 32'h637c777b, 1'b1, 32'h53525150, 32'hed00d153);
        #3;
        chk("reset_ready0", {31'b0, req0_ready}, 32'h0);
        chk("reset_ready1", {31'b0, req1_ready}, 32'h0);
        chk("reset_idle", {31'b0, idle}, 32'h1);
        chk("reset_inflight", {30'b0, inflight}, 32'h0);
        chk("reset_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single round-datapath request
        drive(1'b1, 32'h00010203, 32'h637c777b, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("idle_t1", {31'b0, idle}, 32'h0);
        cyc(1'b0, 1'b0, 1);
        chk("idle_t2", {31'b0, idle}, 32'h0);
        cyc(1'b0, 1'b0, 1);
        chk("idle_after0", {31'b0, idle}, 32'h1);

        // single key-expansion request
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h53525150, 32'hed00d153);
        cyc(1'b0, 1'b1, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1);
        chk("idle_after1", {31'b0, idle}, 32'h1);

        // contention: grants alternate starting from prio 0
        drive(1'b1, 32'h00000000, 32'h63636363, 1'b1, 32'h01010101, 32'h7c7c7c7c);
        cyc(1'b1, 1'b0, 0);
        drive(1'b1, 32'h02020202, 32'h77777777, 1'b1, 32'h01010101, 32'h7c7c7c7c);
        cyc(1'b0, 1'b1, 1);
        drive(1'b1, 32'h02020202, 32'h77777777, 1'b1, 32'h03030303, 32'h7b7b7b7b);
        cyc(1'b1, 1'b0, 2);
        drive(1'b1, 32'h10101010, 32'hcacacaca, 1'b1, 32'h03030303, 32'h7b7b7b7b);
        cyc(1'b0, 1'b1, 2);
        drive(1'b1, 32'h10101010, 32'hcacacaca, 1'b1, 32'h11111111, 32'h82828282);
        cyc(1'b1, 1'b0, 2);
        drive(1'b1, 32'h20202020, 32'hb7b7b7b7, 1'b1, 32'h11111111, 32'h82828282);
        cyc(1'b0, 1'b1, 2);
        drive(1'b1, 32'h20202020, 32'hb7b7b7b7, 1'b1, 32'hffffffff, 32'h16161616);
        cyc(1'b1, 1'b0, 2);

        // en low: no grants, pipe drains, prio (=1) is kept
        en = 1'b0;
        drive(1'b1, 32'h12121212, 32'hc9c9c9c9, 1'b1, 32'hffffffff, 32'h16161616);
        cyc(1'b0, 1'b0, 2);
        cyc(1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 0);
        en = 1'b1;
        cyc(1'b0, 1'b1, 0);
        drive(1'b1, 32'h12121212, 32'hc9c9c9c9, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

        // asynchronous reset with two words in flight and prio=1
        chk("pre_reset_inflight", {30'b0, inflight}, 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp1_drop", {31'b0, rsp1_valid}, 32'h0);
        chk("rst_rsp0_drop", {31'b0, rsp0_valid}, 32'h0);
        chk("rst_inflight", {30'b0, inflight}, 32'h0);
        chk("rst_idle", {31'b0, idle}, 32'h1);
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", {31'b0, idle}, 32'h1);
        drive(1'b1, 32'h13131313, 32'h7d7d7d7d, 1'b1, 32'h00000000, 32'h63636363);
        cyc(1'b1, 1'b0, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h00000000, 32'h63636363);
        cyc(1'b0, 1'b1, 1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 2);
        cyc(1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 0);

        // back-to-back key-expansion words
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h01010101, 32'h7c7c7c7c);
        cyc(1'b0, 1'b1, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h02020202, 32'h77777777);
        cyc(1'b0, 1'b1, 1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h03030303, 32'h7b7b7b7b);
        cyc(1'b0, 1'b1, 2);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h10101010, 32'hcacacaca);
        cyc(1'b0, 1'b1, 2);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 2);
        cyc(1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 0);

        chk("scoreboard_drained", q.size(), 32'h0);
        chk("final_idle", {31'b0, idle}, 32'h1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
